// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM command issuer: FSM state, latched request, row type.
package sdram_pkg;

  localparam int PKG_ROW_WIDTH = 14;
  localparam int PKG_COL_WIDTH = 10;
  localparam int PKG_BANK_BITS = 2;
  localparam int PKG_ID_WIDTH  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_PRE_ISSUE,
    ST_PRE_WAIT,
    ST_ACT_ISSUE,
    ST_ACT_WAIT,
    ST_ACCESS,
    ST_AUTO_PRE
  } issuer_state_t;

  typedef logic [PKG_ROW_WIDTH-1:0] bank_row_t;

  typedef struct packed {
    logic                     write;
    logic [PKG_BANK_BITS-1:0] bank;
    bank_row_t                row;
    logic [PKG_COL_WIDTH-1:0] col;
    logic [PKG_ID_WIDTH-1:0]  id;
  } sdram_req_t;

  function automatic int timer_width(input int limit);
    return ($clog2(limit + 2) > 8) ? $clog2(limit + 2) : 8;
  endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// Saturating wait counter; expired is high once the count has passed LIMIT.
module sdram_wait_timer
  import sdram_pkg::*;
#(
  parameter int LIMIT = 64,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = (count_q > WIDTH'(LIMIT));

endmodule

// File: rtl/sdram_cmd_issuer.sv
// One-request-at-a-time issuer: decides hit/closed/conflict, pulses precharge/activate, issues the access.
// Define SDRAM_CLOSED_PAGE_EN for closed-page policy (auto-precharge after every access).
module sdram_cmd_issuer
  import sdram_pkg::*;
#(
  parameter int ROW_WIDTH       = PKG_ROW_WIDTH,
  parameter int COL_WIDTH       = PKG_COL_WIDTH,
  parameter int NUM_GROUPS      = 2,
  parameter int BANKS_PER_GROUP = 2,
  parameter int BANKS           = NUM_GROUPS * BANKS_PER_GROUP,
  parameter int BANK_BITS       = $clog2(BANKS),
  parameter int ID_WIDTH        = PKG_ID_WIDTH,
  parameter int WAIT_LIMIT      = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [BANK_BITS-1:0]       req_bank,
  input  logic [ROW_WIDTH-1:0]       req_row,
  input  logic [COL_WIDTH-1:0]       req_col,
  input  logic [ID_WIDTH-1:0]        req_id,
  input  logic [BANKS*ROW_WIDTH-1:0] bank_open_row,
  input  logic [BANKS-1:0]           bank_ready,
  input  logic [BANKS-1:0]           bank_active,
  input  logic [BANKS-1:0]           bank_blocked,
  output logic [BANKS-1:0]           precharge,
  output logic [BANKS-1:0]           activate,
  output logic [ROW_WIDTH-1:0]       row_address,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic                       cmd_write,
  output logic [BANK_BITS-1:0]       cmd_bank,
  output logic [ROW_WIDTH-1:0]       cmd_row,
  output logic [COL_WIDTH-1:0]       cmd_col,
  output logic [ID_WIDTH-1:0]        cmd_id,
  output logic                       row_hit,
  output logic                       timeout_err
);

  localparam int TMR_W = timer_width(WAIT_LIMIT);

  issuer_state_t          state_q;
  sdram_req_t             req_q;
  logic                   req_ready_q;
  logic [BANKS-1:0]       pre_q;
  logic [BANKS-1:0]       act_q;
  logic [ROW_WIDTH-1:0]   row_addr_q;
  logic                   cmd_valid_q;
  logic                   row_hit_q;
  logic                   timeout_q;
  logic                   tmr_clr_q;
  logic                   tmr_expired;

  logic                   blk;
  logic                   rdy;
  logic                   act_b;
  logic                   row_match;
  logic [BANKS-1:0]       bank_sel;
  bank_row_t              open_row;

  assign blk       = bank_blocked[req_q.bank];
  assign rdy       = bank_ready[req_q.bank];
  assign act_b     = bank_active[req_q.bank];
  assign open_row  = bank_open_row[int'(req_q.bank) * ROW_WIDTH +: ROW_WIDTH];
  assign row_match = (open_row == req_q.row);
  assign bank_sel  = BANKS'(1) << req_q.bank;

  sdram_wait_timer #(
    .LIMIT (WAIT_LIMIT),
    .WIDTH (TMR_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr_q),
    .en_i      (state_q != ST_IDLE),
    .expired_o (tmr_expired)
  );

  // tmr_clr_q is high for exactly the first cycle of each wait state; the
  // PRE/ACT waits ignore that cycle because the tracker may raise blocked late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      pre_q       <= '0;
      act_q       <= '0;
      row_addr_q  <= '0;
      cmd_valid_q <= 1'b0;
      row_hit_q   <= 1'b0;
      timeout_q   <= 1'b0;
      tmr_clr_q   <= 1'b0;
    end else begin
      row_hit_q <= 1'b0;
      tmr_clr_q <= 1'b0;
      timeout_q <= timeout_q | (tmr_expired & ~tmr_clr_q);
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_q       <= '{write: req_write, bank: req_bank, row: req_row,
                             col: req_col, id: req_id};
            req_ready_q <= 1'b0;
            tmr_clr_q   <= 1'b1;
            state_q     <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          if (!blk) begin
            if (act_b && rdy && row_match) begin
              row_hit_q   <= 1'b1;
              cmd_valid_q <= 1'b1;
              tmr_clr_q   <= 1'b1;
              state_q     <= ST_ACCESS;
            end else if (act_b) begin
              pre_q   <= bank_sel;
              state_q <= ST_PRE_ISSUE;
            end else begin
              act_q      <= bank_sel;
              row_addr_q <= req_q.row;
              state_q    <= ST_ACT_ISSUE;
            end
          end
        end
        ST_PRE_ISSUE: begin
          if (!blk) begin
            pre_q     <= '0;
            tmr_clr_q <= 1'b1;
            state_q   <= ST_PRE_WAIT;
          end
        end
        ST_PRE_WAIT: begin
          if (!tmr_clr_q && rdy && !blk) begin
            act_q      <= bank_sel;
            row_addr_q <= req_q.row;
            state_q    <= ST_ACT_ISSUE;
          end
        end
        ST_ACT_ISSUE: begin
          if (!blk) begin
            act_q      <= '0;
            row_addr_q <= '0;
            tmr_clr_q  <= 1'b1;
            state_q    <= ST_ACT_WAIT;
          end
        end
        ST_ACT_WAIT: begin
          if (!tmr_clr_q && rdy && !blk) begin
            cmd_valid_q <= 1'b1;
            tmr_clr_q   <= 1'b1;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
`ifdef SDRAM_CLOSED_PAGE_EN
            pre_q       <= bank_sel;
            tmr_clr_q   <= 1'b1;
            state_q     <= ST_AUTO_PRE;
`else
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
`endif
          end
        end
`ifdef SDRAM_CLOSED_PAGE_EN
        ST_AUTO_PRE: begin
          if (!blk) begin
            pre_q       <= '0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A held pulse is masked while the bank is blocked, so it reaches the
  // tracker in exactly one unblocked cycle.
  assign precharge   = pre_q & ~bank_blocked;
  assign activate    = act_q & ~bank_blocked;
  assign row_address = row_addr_q;
  assign req_ready   = req_ready_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_write   = req_q.write;
  assign cmd_bank    = req_q.bank;
  assign cmd_row     = req_q.row;
  assign cmd_col     = req_q.col;
  assign cmd_id      = req_q.id;
  assign row_hit     = row_hit_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sdram_cmd_issuer.sv
// Scoreboard bench for sdram_cmd_issuer with a behavioural bank tracker and open-row model.
module tb_sdram_cmd_issuer;

  localparam int RW = 14;
  localparam int CW = 10;
  localparam int NB = 4;
  localparam int BB = 2;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [BB-1:0] req_bank = '0;
  logic [RW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic [IW-1:0] req_id = '0;
  logic req_ready;
  logic [NB*RW-1:0] bank_open_row;
  logic [NB-1:0] bank_ready, bank_active, bank_blocked;
  logic [NB-1:0] precharge, activate;
  logic [RW-1:0] row_address;
  logic cmd_valid;
  logic cmd_ready = 1'b0;
  logic cmd_write;
  logic [BB-1:0] cmd_bank;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic [IW-1:0] cmd_id;
  logic row_hit, timeout_err;

  sdram_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_id(req_id),
    .bank_open_row(bank_open_row), .bank_ready(bank_ready),
    .bank_active(bank_active), .bank_blocked(bank_blocked),
    .precharge(precharge), .activate(activate), .row_address(row_address),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_id(cmd_id),
    .row_hit(row_hit), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Tracker: a pulse makes the bank busy for 1-4 cycles, sometimes one cycle late.
  logic [NB-1:0] t_active = '0, t_pend_pre = '0, t_pend_act = '0;
  logic [NB-1:0] blk_force = '0, blk_rand = '0;
  logic [RW-1:0] t_row [NB] = '{default: '0};
  logic [RW-1:0] t_pend_row [NB] = '{default: '0};
  int t_busy [NB] = '{default: 0};
  bit rand_blk_en = 1'b0;
  bit hold_ready = 1'b0;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (t_busy[b] > 0) t_busy[b] <= t_busy[b] - 1;
      blk_rand[b] <= rand_blk_en && ($urandom_range(0, 15) == 0);
      t_pend_pre[b] <= 1'b0;
      t_pend_act[b] <= 1'b0;
      if (t_pend_pre[b]) begin
        t_active[b] <= 1'b0;
        t_busy[b]   <= $urandom_range(1, 4);
      end
      if (t_pend_act[b]) begin
        t_active[b] <= 1'b1;
        t_row[b]    <= t_pend_row[b];
        t_busy[b]   <= $urandom_range(1, 4);
      end
      if (precharge[b]) begin
        if ($urandom_range(0, 1) == 1) t_pend_pre[b] <= 1'b1;
        else begin
          t_active[b] <= 1'b0;
          t_busy[b]   <= $urandom_range(1, 4);
        end
      end
      if (activate[b]) begin
        if ($urandom_range(0, 1) == 1) begin
          t_pend_act[b] <= 1'b1;
          t_pend_row[b] <= row_address;
        end else begin
          t_active[b] <= 1'b1;
          t_row[b]    <= row_address;
          t_busy[b]   <= $urandom_range(1, 4);
        end
      end
    end
    cmd_ready <= !hold_ready && ($urandom_range(0, 3) != 0);
  end

  always_comb begin
    bank_blocked  = '0;
    bank_ready    = '0;
    bank_active   = '0;
    bank_open_row = '0;
    for (int b = 0; b < NB; b++) begin
      bank_blocked[b] = (t_busy[b] != 0) || blk_force[b] || blk_rand[b];
      bank_ready[b]   = (t_busy[b] == 0);
      bank_active[b]  = t_active[b];
      bank_open_row[b*RW +: RW] = t_row[b];
    end
  end

  typedef struct {
    bit w; int bank; int row; int col; int id;
    bit hit; int npre; int nact;
  } exp_t;

  exp_t exp_q[$];
  bit m_valid [NB] = '{default: 1'b0};
  int m_row [NB] = '{default: 0};
`ifdef SDRAM_CLOSED_PAGE_EN
  int auto_pend = 0;
`endif
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: tallies pulses between commands and checks each accepted command.
  int pre_n = 0, act_n = 0, hit_n = 0, act_row = 0;
  logic [NB-1:0] pre_mask = '0, act_mask = '0;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic ok;
    if (rst) begin
      pre_n = 0; act_n = 0; hit_n = 0; pre_mask = '0; act_mask = '0;
    end else begin
      if ((precharge | activate) != '0) begin
        ok = $onehot(precharge | activate) && ((precharge & activate) == '0)
             && (((precharge | activate) & bank_blocked) == '0);
        chk("pulse_rules", 64'(ok), 64'd1);
        if (precharge != '0) begin pre_n++; pre_mask |= precharge; end
        if (activate != '0) begin
          act_n++; act_mask |= activate; act_row = int'(row_address);
        end
      end
      if (row_hit) hit_n++;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmd: got cmd id=%0d required no command", cmd_id);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_fields", 64'({cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id}),
              64'({e.w, BB'(e.bank), RW'(e.row), CW'(e.col), IW'(e.id)}));
          chk("row_hit_count", 64'(hit_n), 64'(e.hit));
          chk("pre_count", 64'(pre_n), 64'(e.npre));
          chk("act_count", 64'(act_n), 64'(e.nact));
          if (e.nact > 0) begin
            chk("act_bank", 64'(act_mask), 64'(1 << e.bank));
            chk("act_row", 64'(act_row), 64'(e.row));
          end
`ifndef SDRAM_CLOSED_PAGE_EN
          if (e.npre > 0) chk("pre_bank", 64'(pre_mask), 64'(1 << e.bank));
`endif
        end
        pre_n = 0; act_n = 0; hit_n = 0; pre_mask = '0; act_mask = '0;
      end
    end
  end

  task automatic send_req(input bit w, input int bank, input int row, input int col, input int id);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL req_ready_wait: got req_ready=%b required 1", req_ready);
      return;
    end
    e.w = w; e.bank = bank; e.row = row; e.col = col; e.id = id;
    e.hit  = m_valid[bank] && (m_row[bank] == row);
    e.npre = (m_valid[bank] && !e.hit) ? 1 : 0;
    e.nact = e.hit ? 0 : 1;
`ifdef SDRAM_CLOSED_PAGE_EN
    e.npre += auto_pend;
    auto_pend = 1;
    m_valid[bank] = 1'b0;
`else
    m_valid[bank] = 1'b1;
    m_row[bank] = row;
`endif
    exp_q.push_back(e);
    req_write = w; req_bank = BB'(bank); req_row = RW'(row);
    req_col = CW'(col); req_id = IW'(id); req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || req_ready !== 1'b1) && n < 1000) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0 || req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_idle: got pending=%0d req_ready=%b required pending=0 req_ready=1",
               exp_q.size(), req_ready);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] snap;
    bit stable, ready_low;
    int n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_pulses", 64'({precharge, activate}), 64'd0);
    chk("rst_row_address", 64'(row_address), 64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_fields", 64'({cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id}), 64'd0);
    chk("rst_row_hit", 64'(row_hit), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    rst = 1'b0;

    send_req(1'b0, 0, 5, 3, 1);
    wait_idle();

    send_req(1'b0, 0, 5, 7, 2);
`ifndef SDRAM_CLOSED_PAGE_EN
    @(negedge clk);
    chk("hit_decide_no_cmd", 64'(cmd_valid), 64'd0);
    @(negedge clk);
    chk("hit_cmd_valid_n2", 64'(cmd_valid), 64'd1);
    chk("hit_pulse_n2", 64'(row_hit), 64'd1);
`endif
    wait_idle();

    send_req(1'b1, 0, 9, 11, 3);
    wait_idle();

    hold_ready = 1'b1;
    send_req(1'b1, 3, 100, 20, 4);
    n = 0;
    while (cmd_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("stall_cmd_valid", 64'(cmd_valid), 64'd1);
    snap = {cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id};
    stable = 1'b1; ready_low = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if ({cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id} !== snap || cmd_valid !== 1'b1) stable = 1'b0;
      if (req_ready !== 1'b0) ready_low = 1'b0;
    end
    chk("stall_cmd_stable", 64'(stable), 64'd1);
    chk("stall_req_ready_low", 64'(ready_low), 64'd1);
    hold_ready = 1'b0;
    wait_idle();

    rand_blk_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send_req(1'($urandom_range(0, 1)), int'($urandom_range(0, NB-1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 15)));
    end
    wait_idle();
    rand_blk_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_timeout_random", 64'(timeout_err), 64'd0);

    blk_force = 4'b0100;
    send_req(1'b0, 2, int'($urandom_range(0, 3)), 1, 8);
    repeat (50) @(negedge clk);
    chk("timeout_early", 64'(timeout_err), 64'd0);
    repeat (20) @(negedge clk);
    chk("timeout_set", 64'(timeout_err), 64'd1);
    blk_force = 4'b0000;
    wait_idle();
    chk("timeout_sticky", 64'(timeout_err), 64'd1);

    send_req(1'b0, 1, 20, 0, 5);
    wait_idle();
    send_req(1'b0, 1, 21, 0, 6);
    n = 0;
    while (precharge[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("rst_test_precharge_seen", 64'(precharge), 64'd2);
    @(negedge clk);
    blk_force = 4'b0010;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_pulses", 64'({precharge, activate}), 64'd0);
    chk("midrst_row_address", 64'(row_address), 64'd0);
    chk("midrst_cmd", 64'({cmd_valid, cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id}), 64'd0);
    chk("midrst_row_hit", 64'(row_hit), 64'd0);
    chk("midrst_timeout", 64'(timeout_err), 64'd0);
    exp_q.delete();
    m_valid[1] = 1'b0;
`ifdef SDRAM_CLOSED_PAGE_EN
    auto_pend = 0;
`endif
    blk_force = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    send_req(1'b1, 1, 21, 4, 7);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_issuer.md
# sdram_cmd_issuer

Single-request command issuer on the initiator side of the per-bank state tracker. Accepts one memory request at a time, compares it against the tracker's open-row state, and emits the needed precharge/activate pulses to the tracker followed by one read/write command to the data path. Sits between the request queue and the bank state tracker/data path in the memory controller.

## Interface

Parameters:
- ROW_WIDTH, 14: row address bits
- COL_WIDTH, 10: column address bits
- NUM_GROUPS, 2: bank groups
- BANKS_PER_GROUP, 2: banks per group
- BANKS, NUM_GROUPS*BANKS_PER_GROUP: total banks
- BANK_BITS, $clog2(BANKS): bank index width
- ID_WIDTH, 4: request tag width
- WAIT_LIMIT, 64: max cycles in any wait state before timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  issuer can accept a request
- req_write  in  1  1 = write, 0 = read
- req_bank  in  BANK_BITS  target bank
- req_row  in  ROW_WIDTH  target row
- req_col  in  COL_WIDTH  target column
- req_id  in  ID_WIDTH  request tag
- bank_open_row  in  BANKS*ROW_WIDTH  tracker active row per bank
- bank_ready  in  BANKS  tracker ready_to_access
- bank_active  in  BANKS  tracker active flag
- bank_blocked  in  BANKS  tracker blocked flag
- precharge  out  BANKS  one-hot precharge pulse to tracker
- activate  out  BANKS  one-hot activate pulse to tracker
- row_address  out  ROW_WIDTH  row for activate
- cmd_valid  out  1  access command valid
- cmd_ready  in  1  data path accepts command
- cmd_write, cmd_bank, cmd_row, cmd_col, cmd_id  out  as request fields  latched request
- row_hit  out  1  one-cycle pulse: request decided as hit
- timeout_err  out  1  sticky: a wait exceeded WAIT_LIMIT

## Operation

- States: IDLE, DECIDE, PRE_ISSUE, PRE_WAIT, ACT_ISSUE, ACT_WAIT, ACCESS, AUTO_PRE (AUTO_PRE only with macro).
- IDLE: req_ready=1; on req_valid&&req_ready latch all request fields, go DECIDE.
- DECIDE (b = latched bank): if bank_blocked[b] stay. Else if bank_active[b]&&bank_ready[b]&&open_row[b]==row: pulse row_hit, go ACCESS. Else if bank_active[b]: PRE_ISSUE. Else ACT_ISSUE.
- PRE_ISSUE: precharge[b]=1 for exactly this cycle, go PRE_WAIT.
- PRE_WAIT: leave when bank_ready[b]&&!bank_blocked[b] -> ACT_ISSUE.
- ACT_ISSUE: activate[b]=1, row_address=latched row for this cycle, go ACT_WAIT.
- ACT_WAIT: leave when bank_ready[b]&&!bank_blocked[b] -> ACCESS.
- ACCESS: cmd_valid=1, cmd_* stable until cmd_valid&&cmd_ready; then IDLE (or AUTO_PRE).
- precharge/activate are never asserted while bank_blocked[b]=1; at most one bit of either vector high per cycle, never both.
- Wait counter (8+ bits, saturating) clears on entry to DECIDE/PRE_WAIT/ACT_WAIT/ACCESS; exceeding WAIT_LIMIT sets timeout_err (cleared only by rst); FSM continues waiting.

## Timing

- Reset: state IDLE, req_ready=1, precharge=0, activate=0, row_address=0, cmd_valid=0, cmd_* =0, row_hit=0, timeout_err=0, counter 0.
- rst mid-operation: request dropped, all pulses deassert immediately (async).
- Hit: accept at edge N, DECIDE cycle N+1, cmd_valid at N+2.
- Closed bank: activate pulse at N+2; cmd_valid the cycle after tracker shows ready.
- Row conflict: precharge at N+2, activate ≥1 cycle after tracker ready, then ACCESS.
- Tracker asserts blocked the cycle after a pulse; waits must therefore tolerate blocked rising one cycle late.
- req_ready low from accept until the cycle after the ACCESS handshake (or AUTO_PRE exit).

## Configuration

- SDRAM_CLOSED_PAGE_EN defined: after ACCESS handshake go AUTO_PRE: pulse precharge[b] once bank_blocked[b]=0, then IDLE without waiting for precharge completion. Hits only occur if a bank was reopened since.
- Undefined: open-page policy; bank left active after access.

## Structure

- Shared package sdram_pkg: issuer state enum, request struct (write, bank, row, col, id), bank_row_t typedef.
- One sub-module: sdram_wait_timer (clear/enable, saturating count, expired flag).

## Test plan

- Closed bank 0, request read row 5 -> activate=4'b0001, row_address=5 one cycle; cmd_valid after tracker ready; row_hit=0.
- Second read bank 0 row 5 -> row_hit pulse, cmd_valid two cycles after accept, no pre/act.
- Bank 0 open row 5, request row 9 -> precharge 4'b0001, wait, activate row 9, then cmd.
- cmd_ready held low 10 cycles -> cmd_* stable, req_ready=0 throughout.
- Tracker blocked held 70 cycles (WAIT_LIMIT 64) -> timeout_err=1 and stays; completes when unblocked.
- rst asserted during PRE_WAIT -> all outputs to reset values immediately, req_ready=1 after release.
